// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrate, execute, hold response.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_r,
    input  logic [31:0] i_req0_s,
    input  logic [3:0]  i_req0_aluc,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_r,
    input  logic [31:0] i_req1_s,
    input  logic [3:0]  i_req1_aluc,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic [31:0] o_rsp0_alu,
    output logic        o_rsp0_zf,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp1_alu,
    output logic        o_rsp1_zf,
    output logic [31:0] o_alu_r,
    output logic [31:0] o_alu_s,
    output logic [3:0]  o_alu_aluc,
    input  logic [31:0] i_alu_res,
    input  logic        i_alu_zf,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] r_q, r_d;
    logic [31:0] s_q, s_d;
    logic [3:0]  aluc_q, aluc_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp0_alu_q, rsp0_alu_d;
    logic [31:0] rsp1_alu_q, rsp1_alu_d;
    logic        rsp0_zf_q, rsp0_zf_d;
    logic        rsp1_zf_q, rsp1_zf_d;

    logic any_valid;
    logic win1;
    logic idle;
    logic rsp_taken;

    assign any_valid = i_req0_valid | i_req1_valid;
    assign idle      = (state_q == StIdle);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win1 = i_req1_valid & ~i_req0_valid;
`else
    // last_q holds the index granted last; requester 1 wins a tie only if 0 went last.
    assign win1 = i_req1_valid & (~i_req0_valid | ~last_q);
`endif

    // Gated by reset so ready stays low while reset is held even with valid inputs.
    assign o_req0_ready = i_rst_n & idle & i_req0_valid & ~win1;
    assign o_req1_ready = i_rst_n & idle & win1;

    assign rsp_taken = grant_q ? i_rsp1_ready : i_rsp0_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        r_d         = r_q;
        s_d         = s_q;
        aluc_d      = aluc_q;
        rsp_valid_d = rsp_valid_q;
        rsp0_alu_d  = rsp0_alu_q;
        rsp1_alu_d  = rsp1_alu_q;
        rsp0_zf_d   = rsp0_zf_q;
        rsp1_zf_d   = rsp1_zf_q;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = win1;
                    r_d     = win1 ? i_req1_r    : i_req0_r;
                    s_d     = win1 ? i_req1_s    : i_req0_s;
                    aluc_d  = win1 ? i_req1_aluc : i_req0_aluc;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (grant_q) begin
                    rsp1_alu_d = i_alu_res;
                    rsp1_zf_d  = i_alu_zf;
                end else begin
                    rsp0_alu_d = i_alu_res;
                    rsp0_zf_d  = i_alu_zf;
                end
                rsp_valid_d[grant_q] = 1'b1;
                state_d              = StResp;
            end
            StResp: begin
                if (rsp_taken) begin
                    rsp_valid_d[grant_q] = 1'b0;
                    last_d               = grant_q;
                    state_d              = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            r_q         <= '0;
            s_q         <= '0;
            aluc_q      <= '0;
            rsp_valid_q <= '0;
            rsp0_alu_q  <= '0;
            rsp1_alu_q  <= '0;
            rsp0_zf_q   <= 1'b0;
            rsp1_zf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            r_q         <= r_d;
            s_q         <= s_d;
            aluc_q      <= aluc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_alu_q  <= rsp0_alu_d;
            rsp1_alu_q  <= rsp1_alu_d;
            rsp0_zf_q   <= rsp0_zf_d;
            rsp1_zf_q   <= rsp1_zf_d;
        end
    end

    assign o_alu_r      = r_q;
    assign o_alu_s      = s_q;
    assign o_alu_aluc   = aluc_q;
    assign o_rsp0_valid = rsp_valid_q[0];
    assign o_rsp1_valid = rsp_valid_q[1];
    assign o_rsp0_alu   = rsp0_alu_q;
    assign o_rsp1_alu   = rsp1_alu_q;
    assign o_rsp0_zf    = rsp0_zf_q;
    assign o_rsp1_zf    = rsp1_zf_q;
    assign o_busy       = ~idle;

endmodule
